// File: rtl/muldiv_hilo_ctrl.sv
`timescale 1ns/1ps
// HI/LO sequencer: pipelined-delay multiply, 32-step restoring divide, MTHI/MTLO moves.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built when MULDIV_MADD_EN is defined.
//
// state  | meaning
// S_IDLE | accepting ops; MTHI/MTLO complete here in one cycle
// S_MUL  | product already latched, waiting out the multiply latency
// S_DIV  | one restoring iteration per cycle (hi_q = remainder, lo_q = quotient)
// S_DONE | presenting result, held until pipe_ready
module muldiv_hilo_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [3:0]  op_code,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   input  logic        pipe_ready,
   input  logic        exception_flush,
   output logic        stall_req,
   output logic        hi_wren,
   output logic        lo_wren,
   output logic [31:0] hi_wt_val,
   output logic [31:0] lo_wt_val,
   output logic        complete
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [5:0] MUL_CNT = 6'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
   logic        neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;

   logic        acc_en, acc_sub;
   logic [63:0] acc_val;

`ifdef MULDIV_MADD_EN
   assign acc_en  = (op_code == 4'd7) || (op_code == 4'd8) || (op_code == 4'd9) || (op_code == 4'd10);
   assign acc_sub = (op_code == 4'd9) || (op_code == 4'd10);
   assign acc_val = {hi_in, lo_in};
`else
   logic unused_acc;
   assign acc_en     = 1'b0;
   assign acc_sub    = 1'b0;
   assign acc_val    = '0;
   assign unused_acc = ^{hi_in, lo_in};
`endif

   logic        is_mul, mul_signed, is_div, div_signed;
   logic [63:0] mul_a, mul_b, prod, mul_res;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;

   always_comb begin
      is_mul     = (op_code == 4'd1) || (op_code == 4'd2) || acc_en;
      mul_signed = (op_code == 4'd1) || (op_code == 4'd7) || (op_code == 4'd9);
      is_div     = (op_code == 4'd3) || (op_code == 4'd4);
      div_signed = (op_code == 4'd3);
      mul_a      = mul_signed ? {{32{src_a[31]}}, src_a} : {32'b0, src_a};
      mul_b      = mul_signed ? {{32{src_b[31]}}, src_b} : {32'b0, src_b};
      prod       = mul_a * mul_b;
      if (acc_en) begin
         mul_res = acc_sub ? (acc_val - prod) : (acc_val + prod);
      end else begin
         mul_res = prod;
      end
      a_neg = div_signed & src_a[31];
      b_neg = div_signed & src_b[31];
      a_mag = a_neg ? (32'd0 - src_a) : src_a;
      b_mag = b_neg ? (32'd0 - src_b) : src_b;
   end

   // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
   logic [32:0] rem_sh, trial;
   logic        fits;
   logic [31:0] new_rem, new_quot, q_fix, r_fix;

   always_comb begin
      rem_sh   = {hi_q, lo_q[31]};
      trial    = rem_sh - {1'b0, dvs_q};
      fits     = ~trial[32];
      new_rem  = fits ? trial[31:0] : rem_sh[31:0];
      new_quot = {lo_q[30:0], fits};
      // Divide-by-zero keeps the all-ones quotient unsigned; the remainder fixup restores src_a.
      q_fix    = (neg_q_q && !dz_q) ? (32'd0 - new_quot) : new_quot;
      r_fix    = neg_r_q ? (32'd0 - new_rem) : new_rem;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dvs_d     = dvs_q;
      neg_q_d   = neg_q_q;
      neg_r_d   = neg_r_q;
      dz_d      = dz_q;
      stall_req = 1'b0;
      hi_wren   = 1'b0;
      lo_wren   = 1'b0;
      hi_wt_val = 32'd0;
      lo_wt_val = 32'd0;
      complete  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               if (is_mul) begin
                  stall_req = 1'b1;
                  {hi_d, lo_d} = mul_res;
                  if (MUL_LAT <= 1) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_MUL;
                     cnt_d   = MUL_CNT;
                  end
               end else if (is_div) begin
                  stall_req = 1'b1;
                  hi_d      = 32'd0;
                  lo_d      = a_mag;
                  dvs_d     = b_mag;
                  neg_q_d   = a_neg ^ b_neg;
                  neg_r_d   = a_neg;
                  dz_d      = (src_b == 32'd0);
                  cnt_d     = 6'd31;
                  state_d   = S_DIV;
               end else if (op_code == 4'd5) begin
                  complete  = 1'b1;
                  hi_wren   = 1'b1;
                  hi_wt_val = src_a;
               end else if (op_code == 4'd6) begin
                  complete  = 1'b1;
                  lo_wren   = 1'b1;
                  lo_wt_val = src_a;
               end
            end
         end
         S_MUL: begin
            stall_req = 1'b1;
            if (cnt_q == 6'd0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         S_DIV: begin
            stall_req = 1'b1;
            if (cnt_q == 6'd0) begin
               hi_d    = r_fix;
               lo_d    = q_fix;
               state_d = S_DONE;
            end else begin
               hi_d  = new_rem;
               lo_d  = new_quot;
               cnt_d = cnt_q - 6'd1;
            end
         end
         S_DONE: begin
            complete  = 1'b1;
            hi_wren   = 1'b1;
            lo_wren   = 1'b1;
            hi_wt_val = hi_q;
            lo_wt_val = lo_q;
            stall_req = ~pipe_ready;
            if (pipe_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (reset || exception_flush) begin
         state_d   = S_IDLE;
         cnt_d     = 6'd0;
         hi_d      = 32'd0;
         lo_d      = 32'd0;
         dvs_d     = 32'd0;
         neg_q_d   = 1'b0;
         neg_r_d   = 1'b0;
         dz_d      = 1'b0;
         stall_req = 1'b0;
         hi_wren   = 1'b0;
         lo_wren   = 1'b0;
         hi_wt_val = 32'd0;
         lo_wt_val = 32'd0;
         complete  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         dvs_q   <= 32'd0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dvs_q   <= dvs_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
`timescale 1ns/1ps
// Bench for muldiv_hilo_ctrl: directed cases plus randomized ops against an arithmetic model.
module tb_muldiv_hilo_ctrl;
   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        reset, op_valid, pipe_ready, exception_flush;
   logic [3:0]  op_code;
   logic [31:0] src_a, src_b, hi_in, lo_in;
   logic        stall_req, hi_wren, lo_wren, complete;
   logic [31:0] hi_wt_val, lo_wt_val;

   int tests = 0;
   int fails = 0;

   muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .src_a(src_a), .src_b(src_b), .hi_in(hi_in), .lo_in(lo_in),
      .pipe_ready(pipe_ready), .exception_flush(exception_flush),
      .stall_req(stall_req), .hi_wren(hi_wren), .lo_wren(lo_wren),
      .hi_wt_val(hi_wt_val), .lo_wt_val(lo_wt_val), .complete(complete)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain SV arithmetic on the architectural rules.
   task automatic model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hin, input logic [31:0] lin,
                        output logic [31:0] ehi, output logic [31:0] elo, output int elat);
      int              sa, sb;
      longint          sp;
      longint unsigned up, acc, res;
      sa   = a;
      sb   = b;
      acc  = {hin, lin};
      elat = MUL_LAT;
      res  = 0;
      case (code)
         4'd1, 4'd7, 4'd9: begin sp = longint'(sa) * longint'(sb); res = sp; end
         4'd2, 4'd8, 4'd10: begin up = a; up = up * b; res = up; end
         default: res = 0;
      endcase
      if (code == 4'd7 || code == 4'd8) res = acc + res;
      if (code == 4'd9 || code == 4'd10) res = acc - res;
      {ehi, elo} = res;
      if (code == 4'd3 || code == 4'd4) begin
         elat = 33;
         if (b == 0) begin
            elo = 32'hFFFF_FFFF;
            ehi = a;
         end else if (code == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            elo = 32'h8000_0000;
            ehi = 32'd0;
         end else if (code == 4'd3) begin
            elo = sa / sb;
            ehi = sa % sb;
         end else begin
            elo = a / b;
            ehi = a % b;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hin, input logic [31:0] lin,
                         input int hold);
      logic [31:0] ehi, elo;
      int          elat, lat;
      logic        stall_bad;
      model(code, a, b, hin, lin, ehi, elo, elat);
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
      hi_in = hin; lo_in = lin; pipe_ready = (hold == 0);
      @(negedge clk);
      chk({tag, "_issue_stall"}, stall_req, 1'b1);
      lat = 0;
      stall_bad = 1'b0;
      while (complete !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         hi_in = $urandom; lo_in = $urandom;
         @(negedge clk);
         lat++;
         if (complete !== 1'b1 && stall_req !== 1'b1) stall_bad = 1'b1;
      end
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_busy_stall"}, stall_bad, 1'b0);
      chk({tag, "_wren"}, {hi_wren, lo_wren}, 2'b11);
      chk({tag, "_result"}, {hi_wt_val, lo_wt_val}, {ehi, elo});
      chk({tag, "_done_stall"}, stall_req, (hold != 0));
      for (int j = 1; j <= hold; j++) begin
         @(posedge clk); #1;
         pipe_ready = (j == hold);
         @(negedge clk);
         chk({tag, "_hold_result"}, {complete, hi_wt_val, lo_wt_val}, {1'b1, ehi, elo});
         chk({tag, "_hold_stall"}, stall_req, (j != hold));
      end
      @(posedge clk); #1;
      op_valid = 1'b0; pipe_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_idle_after"}, {complete, stall_req}, 2'b00);
   endtask

   task automatic mt_op(input string tag, input logic [3:0] code, input logic [31:0] v);
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = code; src_a = v; exception_flush = 1'b0;
      @(negedge clk);
      chk({tag, "_ctl"}, {complete, stall_req, hi_wren, lo_wren},
          {1'b1, 1'b0, (code == 4'd5), (code == 4'd6)});
      chk({tag, "_val"}, (code == 4'd5) ? hi_wt_val : lo_wt_val, v);
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   initial begin
      logic [3:0]  codes [$];
      logic [3:0]  c;
      logic [31:0] ra, rb;
      logic        seen;

      reset = 1'b1; op_valid = 1'b1; op_code = 4'd5; src_a = 32'h55; src_b = 0;
      hi_in = 0; lo_in = 0; pipe_ready = 1'b1; exception_flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {complete, stall_req, hi_wren, lo_wren, hi_wt_val, lo_wt_val}, '0);
      @(posedge clk); #1;
      reset = 1'b0; op_valid = 1'b0;

      run_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
      run_op("divu_100_7", 4'd4, 32'd100, 32'd7, 0, 0, 0);
      run_op("div_neg7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 1);
      run_op("divu_by0", 4'd4, 32'd5, 32'd0, 0, 0, 0);
      run_op("div_by0_neg", 4'd3, 32'hFFFF_FFF0, 32'd0, 0, 0, 0);
      run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      run_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 3);

`ifdef MULDIV_MADD_EN
      run_op("madd_carry", 4'd7, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
      run_op("msub_signed", 4'd9, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, 0);
`else
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = 4'd7; src_a = 1; src_b = 1; hi_in = 0; lo_in = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("madd_disabled", {complete, stall_req, hi_wren, lo_wren}, 4'b0000);
      @(posedge clk); #1;
      op_valid = 1'b0;
`endif

      @(posedge clk); #1;
      op_valid = 1'b1; op_code = 4'd0;
      @(negedge clk);
      chk("nop", {complete, stall_req, hi_wren, lo_wren}, 4'b0000);
      @(posedge clk); #1;
      op_code = 4'd15;
      @(negedge clk);
      chk("undef_op", {complete, stall_req, hi_wren, lo_wren}, 4'b0000);
      @(posedge clk); #1;
      op_valid = 1'b0;

      mt_op("mthi", 4'd5, 32'hDEAD_BEEF);

      // Flush in the middle of a divide, then MTLO in the very next cycle.
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = 4'd3; src_a = 32'd1000; src_b = 32'd3;
      @(negedge clk);
      chk("flush_issue_stall", stall_req, 1'b1);
      repeat (9) @(posedge clk);
      @(posedge clk); #1;
      exception_flush = 1'b1;
      @(negedge clk);
      chk("flush_forced", {complete, stall_req, hi_wren, lo_wren}, 4'b0000);
      mt_op("mtlo_after_flush", 4'd6, 32'h1234);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (complete === 1'b1) seen = 1'b1;
      end
      chk("flush_no_complete", seen, 1'b0);

      // Flush coinciding with issue: nothing issues, DUT stays idle.
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = 4'd4; src_a = 9; src_b = 2; exception_flush = 1'b1;
      @(negedge clk);
      chk("flush_at_issue", {complete, stall_req}, 2'b00);
      mt_op("mthi_after_flush_issue", 4'd5, 32'hABCD);
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = 4'd6; src_a = 32'h77; exception_flush = 1'b1;
      @(negedge clk);
      chk("flush_kills_mtlo", {complete, lo_wren}, 2'b00);
      @(posedge clk); #1;
      op_valid = 1'b0; exception_flush = 1'b0;

      codes = '{4'd1, 4'd2, 4'd3, 4'd4};
`ifdef MULDIV_MADD_EN
      codes.push_back(4'd7); codes.push_back(4'd8); codes.push_back(4'd9); codes.push_back(4'd10);
`endif
      for (int n = 0; n < 24; n++) begin
         c  = codes[$urandom_range(0, codes.size() - 1)];
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = $urandom_range(0, 9);
            1: rb = 32'd0;
            2: rb = -$urandom_range(1, 9);
            default: ;
         endcase
         run_op("rand", c, ra, rb, $urandom, $urandom, $urandom_range(0, 2));
         if (n % 6 == 0) mt_op("rand_mt", ($urandom_range(0, 1) != 0) ? 4'd5 : 4'd6, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
Sequencer for the HI/LO register pair. Accepts multiply, divide and move-to-HI/LO ops from the execute stage and runs a pipelined-delay multiplier or a 32-iteration radix-2 divider. Drives the HI/LO write port with wren, values, ready and complete, and stalls the pipeline while busy. Sits in EXE, between the decode/issue logic and the HI/LO register pair.

Parameters:
MUL_LAT, 2, cycles from multiply issue to complete; legal range 1..8.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  op present in EXE; held stable while stall_req=1
op_code  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others NOP
src_a  in  32  rs operand (dividend / multiplicand / move value)
src_b  in  32  rt operand (divisor / multiplier)
hi_in  in  32  current HI read value (accumulate ops only)
lo_in  in  32  current LO read value (accumulate ops only)
pipe_ready  in  1  downstream accepts the result this cycle
exception_flush  in  1  kill in-flight op
stall_req  out  1  hold EXE and earlier stages
hi_wren  out  1  HI write enable
lo_wren  out  1  LO write enable
hi_wt_val  out  32  HI write data
lo_wt_val  out  32  LO write data
complete  out  1  result valid this cycle

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset and flush both force IDLE and clear all registered results. Every output is 0 in the reset cycle and after.
- Issue (IDLE, op_valid=1, MUL/DIV/accumulate op):
  - Operands are latched at cycle T.
  - stall_req=1 from T combinationally.
  - Next state is MUL or DIV.
- MTHI/MTLO in IDLE: single cycle, no state change, stall_req=0.
  - complete=1 in the same cycle.
  - MTHI drives hi_wren=1 with hi_wt_val=src_a. MTLO drives lo_wren=1 with lo_wt_val=src_a.
- NOP, or op_valid=0: complete=0, no wren, stall_req=0.
- MUL:
  - 64-bit product of src_a and src_b; signed for MULT/MADD/MSUB, unsigned otherwise.
  - A counter runs for MUL_LAT-1 cycles, so DONE is entered at T+MUL_LAT.
- DIV:
  - Operands are converted to magnitudes (DIV only).
  - 32 restoring iterations in cycles T+1..T+32; DONE at T+33.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): lo=32'hFFFF_FFFF, hi=src_a. Same 33-cycle latency.
- Special case: DIV 0x80000000 / -1 gives lo=0x80000000, hi=0.
- DONE:
  - complete=1, hi_wren=lo_wren=1, results held stable.
  - Stays in DONE while pipe_ready=0, with stall_req=1.
  - With pipe_ready=1, stall_req=0 in that cycle and next state is IDLE.
- Back-to-back ops: a new op can issue from the IDLE cycle after DONE. No op is accepted while in DONE.
- exception_flush=1 in any state:
  - complete, hi_wren, lo_wren and stall_req are forced to 0 combinationally.
  - Next state is IDLE.
  - The op is discarded, including an MTHI/MTLO in its issue cycle.
- Flush and issue in the same cycle: the flush wins and nothing issues.

Optional Feature:
MULDIV_MADD_EN
- Defined: ops 7-10 take the MUL path. The 64-bit product is added to (7, 8) or subtracted from (9, 10) {hi_in, lo_in}.
  - {hi_in, lo_in} is sampled at issue cycle T.
  - Result is mod 2^64, with the same MUL_LAT latency.
- Undefined: ops 7-10 decode as NOP and hi_in/lo_in are ignored.

Test Plan:
- MULT src_a=0xFFFFFFFD, src_b=5, MUL_LAT=2 -> DONE at T+2: hi=0xFFFFFFFF, lo=0xFFFFFFF1, complete=1, stall_req=1 T..T+1.
- DIVU 100/7 -> at T+33: lo=14, hi=2, complete=1. Then DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5/0 -> T+33: lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV issued, exception_flush at T+10 -> complete and wren stay 0, state IDLE at T+11. MTLO 0x1234 at T+11 -> lo_wren=1, lo_wt_val=0x1234 same cycle.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with pipe_ready=0 for 3 cycles in DONE -> hi=0xFFFFFFFE, lo=1 held with stall_req=1. Release -> stall_req=0 that cycle, IDLE next.
- With MULDIV_MADD_EN: MADD hi_in=0, lo_in=0xFFFFFFFF, 1*1 -> hi=1, lo=0. Without it: same op -> complete=0, no stall.
